// File: rtl/gpio_vector_monitor.sv
// -----------------------------------------------------------------------------
// gpio_vector_monitor
//
// Watches a GPIO slice that firmware steps through a known counting sequence
// (START_VAL, START_VAL+STEP, ... END_VAL, modulo 2^WIDTH). It reports pass
// when the end value is reached, and fail on a wrong value or a stall.
//
// Optional feature: define GPIO_VECMON_CAPTURE_EN to keep the first wrong
// accepted value on mismatch_val. Without the macro mismatch_val is tied to 0
// and the capture register does not exist.
//
// Ports
//   clock        : sole clock, rising edge
//   reset        : asynchronous, active-high reset
//   enable       : run request; low returns the monitor to IDLE
//   vec_in       : asynchronous GPIO slice [WIDTH-1:0]
//   busy         : high while waiting for the start value or tracking
//   step_ok      : one-cycle pulse per accepted correct value
//   pass         : sticky, end value reached
//   fail         : sticky, wrong value or stall
//   timeout      : sticky, the fail was caused by a stall
//   expected     : next value awaited [WIDTH-1:0]
//   mismatch_val : first wrong accepted value (capture build only)
//   state_dbg    : current FSM state encoding, for checkers/debug
//
// Parameters: WIDTH, START_VAL, END_VAL, STEP, STABLE (1..15), TIMEOUT.
// -----------------------------------------------------------------------------
module gpio_vector_monitor #(
  parameter int WIDTH     = 8,
  parameter int START_VAL = 0,
  parameter int END_VAL   = 33,
  parameter int STEP      = 1,
  parameter int STABLE    = 2,
  parameter int TIMEOUT   = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] vec_in,
  output logic             busy,
  output logic             step_ok,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [WIDTH-1:0] expected,
  output logic [WIDTH-1:0] mismatch_val,
  output logic [2:0]       state_dbg
);

  localparam logic [WIDTH-1:0] START_V = WIDTH'(START_VAL);
  localparam logic [WIDTH-1:0] END_V   = WIDTH'(END_VAL);
  localparam logic [WIDTH-1:0] STEP_V  = WIDTH'(STEP);
  localparam logic [4:0]       STABLE_N = 5'(STABLE);
  // The stall counter only has to reach TIMEOUT-1.
  localparam int               TCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TCW-1:0]   STALL_LAST = TCW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_START = 3'd1,
    S_TRACK      = 3'd2,
    S_PASS       = 3'd3,
    S_FAIL       = 3'd4
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;
  logic [WIDTH-1:0] prev_sample;
  logic [3:0]       run_cnt;
  logic [4:0]       run_n;
  logic             acc_valid;
  logic             new_val;
  logic [WIDTH-1:0] last_val;
  logic [TCW-1:0]   stall_cnt;
  logic             stall_hit;

  assign state_dbg = state;

  // Two-flop synchroniser; nothing downstream looks at vec_in directly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= vec_in;
      sync_q2 <= sync_q1;
    end
  end

  // Stability filter. run_n is the length of the current run of equal
  // synchronised samples including this cycle. Once it reaches STABLE the
  // value stays accepted for as long as it is held, so the FSM sees a level
  // rather than a one-shot event; that is why TRACK ignores repeats of the
  // last accepted value. run_cnt saturates at STABLE.
  always_comb begin
    run_n = 5'd1;
    if (sync_q2 == prev_sample) begin
      run_n = {1'b0, run_cnt} + 5'd1;
    end
  end

  assign acc_valid = (run_n >= STABLE_N);
  assign new_val   = acc_valid && (sync_q2 != last_val);
  assign stall_hit = (stall_cnt == STALL_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_sample <= '0;
      run_cnt     <= '0;
    end else begin
      prev_sample <= sync_q2;
      run_cnt     <= acc_valid ? STABLE_N[3:0] : run_n[3:0];
    end
  end

  // Main sequencer. An advance is tested before the stall limit, so an
  // advance on the same cycle as the limit wins and clears the counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      step_ok   <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      expected  <= START_V;
      last_val  <= '0;
      stall_cnt <= '0;
    end else begin
      step_ok <= 1'b0;
      if (!enable) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        pass      <= 1'b0;
        fail      <= 1'b0;
        timeout   <= 1'b0;
        expected  <= START_V;
        stall_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state     <= S_WAIT_START;
            busy      <= 1'b1;
            stall_cnt <= '0;
          end
          S_WAIT_START: begin
            if (acc_valid && (sync_q2 == START_V)) begin
              stall_cnt <= '0;
              last_val  <= START_V;
              if (START_V == END_V) begin
                state <= S_PASS;
                busy  <= 1'b0;
                pass  <= 1'b1;
              end else begin
                state    <= S_TRACK;
                expected <= START_V + STEP_V;
              end
            end else if (stall_hit) begin
              state   <= S_FAIL;
              busy    <= 1'b0;
              fail    <= 1'b1;
              timeout <= 1'b1;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end
          S_TRACK: begin
            if (new_val && (sync_q2 == expected)) begin
              step_ok   <= 1'b1;
              stall_cnt <= '0;
              last_val  <= sync_q2;
              if (sync_q2 == END_V) begin
                state <= S_PASS;
                busy  <= 1'b0;
                pass  <= 1'b1;
              end else begin
                expected <= expected + STEP_V;
              end
            end else if (new_val) begin
              state <= S_FAIL;
              busy  <= 1'b0;
              fail  <= 1'b1;
            end else if (stall_hit) begin
              state   <= S_FAIL;
              busy    <= 1'b0;
              fail    <= 1'b1;
              timeout <= 1'b1;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end
          S_PASS, S_FAIL: begin
            // Terminal until enable drops or reset.
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef GPIO_VECMON_CAPTURE_EN
  // Same condition as the mismatch branch of TRACK above.
  logic             mis_fire;
  logic [WIDTH-1:0] mis_q;

  assign mis_fire = enable && (state == S_TRACK) && new_val && (sync_q2 != expected);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mis_q <= '0;
    end else if (!enable || (state == S_IDLE)) begin
      mis_q <= '0;
    end else if (mis_fire) begin
      mis_q <= sync_q2;
    end
  end

  assign mismatch_val = mis_q;
`else
  assign mismatch_val = '0;
`endif

endmodule

// File: tb/tb_gpio_vector_monitor.sv
// -----------------------------------------------------------------------------
// tb_gpio_vector_monitor
//
// Bench for gpio_vector_monitor. dut uses default parameters; dut_w uses
// START_VAL=250, END_VAL=3 to exercise wrap-around. Directed table rows, hand
// sequences for stall/glitch/reset, then random segment streams scored against
// a segment-level reference model.
// -----------------------------------------------------------------------------
module tb_gpio_vector_monitor;

`ifdef GPIO_VECMON_CAPTURE_EN
  localparam bit CAPTURE = 1'b1;
`else
  localparam bit CAPTURE = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset;
  always #5 clock = ~clock;

  logic       enable, enable_w;
  logic [7:0] vec_in, vec_w;
  logic       busy, step_ok, pass, fail, timeout;
  logic [7:0] expected, mismatch_val;
  logic [2:0] state_dbg;
  logic       busy_w, step_ok_w, pass_w, fail_w, timeout_w;
  logic [7:0] expected_w, mismatch_w;
  logic [2:0] state_dbg_w;

  gpio_vector_monitor dut (
    .clock(clock), .reset(reset), .enable(enable), .vec_in(vec_in),
    .busy(busy), .step_ok(step_ok), .pass(pass), .fail(fail),
    .timeout(timeout), .expected(expected), .mismatch_val(mismatch_val),
    .state_dbg(state_dbg)
  );

  gpio_vector_monitor #(.START_VAL(250), .END_VAL(3)) dut_w (
    .clock(clock), .reset(reset), .enable(enable_w), .vec_in(vec_w),
    .busy(busy_w), .step_ok(step_ok_w), .pass(pass_w), .fail(fail_w),
    .timeout(timeout_w), .expected(expected_w), .mismatch_val(mismatch_w),
    .state_dbg(state_dbg_w)
  );

  // ---------------- monitors ----------------
  int cyc = 0, step_cnt = 0, step_cnt_w = 0, last_step_cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (step_ok) begin
      step_cnt      <= step_cnt + 1;
      last_step_cyc <= cyc;
    end
    if (step_ok_w) step_cnt_w <= step_cnt_w + 1;
  end

  // ---------------- scoreboard ----------------
  int checks = 0, errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive(input logic [7:0] v, input int hold);
    vec_in = v;
    tick(hold);
  endtask

  task automatic drive_w(input logic [7:0] v, input int hold);
    vec_w = v;
    tick(hold);
  endtask

  task automatic check_reset_vals();
    check("rst_busy", busy, 0);
    check("rst_step_ok", step_ok, 0);
    check("rst_pass", pass, 0);
    check("rst_fail", fail, 0);
    check("rst_timeout", timeout, 0);
    check("rst_expected", expected, 0);
    check("rst_mismatch", mismatch_val, 0);
    check("rst_state", state_dbg, 0);
    check("rst_w_expected", expected_w, 250);
    check("rst_w_busy", busy_w, 0);
    check("rst_w_state", state_dbg_w, 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int good;    // drive 0..good
    int bad;     // then this wrong value (-1: none)
    int hold;    // cycles per value
    int e_pass;
    int e_fail;
    int e_exp;
    int e_mis;
    int e_busy;
    int e_steps;
  } vec_t;
  vec_t tbl[6];

  // ---------------- random stream + reference model ----------------
  typedef struct {
    logic [7:0] v;
    int         dur;
  } seg_t;
  seg_t segs[$];

  task automatic push_seg(input logic [7:0] v, input int dur);
    seg_t s;
    s.v = v;
    s.dur = dur;
    segs.push_back(s);
  endtask

  // Replays the segment list at the level of "values the firmware showed":
  // runs shorter than STABLE(2) are noise, nothing counts before a 0, then
  // each new value must be previous+1 until 33.
  function automatic void run_model(output int m_pass, output int m_fail,
                                    output int m_exp, output int m_mis,
                                    output int m_steps);
    bit started = 1'b0;
    int last = 0;
    m_pass = 0; m_fail = 0; m_exp = 0; m_mis = 0; m_steps = 0;
    foreach (segs[i]) begin
      if (segs[i].dur < 2) continue;
      if (m_pass != 0 || m_fail != 0) break;
      if (!started) begin
        if (segs[i].v == 8'd0) begin
          started = 1'b1;
          last = 0;
          m_exp = 1;
        end
        continue;
      end
      if (int'(segs[i].v) == last) continue;
      if (int'(segs[i].v) == m_exp) begin
        m_steps++;
        last = int'(segs[i].v);
        if (last == 33) m_pass = 1;
        else m_exp = (m_exp + 1) % 256;
      end else begin
        m_fail = 1;
        m_mis = int'(segs[i].v);
      end
    end
  endfunction

  int base, got, cur, r, dur;
  int m_pass, m_fail, m_exp, m_mis, m_steps;
  logic [7:0] last_real;
  bit prev_glitch;

  initial begin
    tbl[0] = '{33, -1, 20, 1, 0, 33, 0, 0, 33};
    tbl[1] = '{ 5,  7, 10, 0, 1,  6, 7, 0,  5};
    tbl[2] = '{ 0,  2,  6, 0, 1,  1, 2, 0,  0};
    tbl[3] = '{ 3,  9,  5, 0, 1,  4, 9, 0,  3};
    tbl[4] = '{10, -1,  4, 0, 0, 11, 0, 1, 10};
    tbl[5] = '{12, 11,  5, 0, 1, 13, 11, 0, 12};

    reset = 1'b1; enable = 1'b0; enable_w = 1'b0; vec_in = '0; vec_w = '0;
    tick(3);
    check_reset_vals();
    reset = 1'b0;
    tick(2);

    // Directed table rows.
    for (int i = 0; i < 6; i++) begin
      enable = 1'b0; vec_in = '0;
      tick(3);
      check("idle_pass", pass, 0);
      check("idle_fail", fail, 0);
      check("idle_busy", busy, 0);
      base = step_cnt;
      enable = 1'b1;
      for (int v = 0; v <= tbl[i].good; v++) drive(8'(v), tbl[i].hold);
      if (tbl[i].bad >= 0) drive(8'(tbl[i].bad), tbl[i].hold);
      tick(6);
      check("tbl_pass", pass, tbl[i].e_pass);
      check("tbl_fail", fail, tbl[i].e_fail);
      check("tbl_timeout", timeout, 0);
      check("tbl_expected", expected, tbl[i].e_exp);
      check("tbl_busy", busy, tbl[i].e_busy);
      check("tbl_steps", step_cnt - base, tbl[i].e_steps);
      check("tbl_mismatch", mismatch_val, CAPTURE ? tbl[i].e_mis : 0);
    end

    // Stall in TRACK: hold 10, fail lands exactly 1000 cycles after its accept.
    enable = 1'b0; vec_in = '0;
    tick(3);
    enable = 1'b1;
    for (int v = 0; v <= 9; v++) drive(8'(v), 20);
    vec_in = 8'd10;
    got = 0;
    for (int k = 0; k < 1300; k++) begin
      @(negedge clock);
      if (fail) begin got = 1; break; end
    end
    check("to_seen", got, 1);
    check("to_delay", cyc - last_step_cyc, 1000);
    check("to_timeout", timeout, 1);
    check("to_expected", expected, 11);
    check("to_pass", pass, 0);
    check("to_busy", busy, 0);
    check("to_mismatch", mismatch_val, 0);
    enable = 1'b0;
    tick(2);
    check("to_clr_timeout", timeout, 0);
    check("to_clr_fail", fail, 0);
    check("to_clr_state", state_dbg, 0);

    // Stall in WAIT_START: start value never shows up.
    vec_in = 8'd5;
    tick(3);
    enable = 1'b1;
    got = 0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clock);
      if (fail) begin got = 1; break; end
    end
    check("ws_to_seen", got, 1);
    check("ws_to_timeout", timeout, 1);
    check("ws_to_expected", expected, 0);
    enable = 1'b0;

    // Wrap-around instance: 250..255, 0..3.
    vec_w = 8'd250;
    tick(3);
    enable_w = 1'b1;
    base = step_cnt_w;
    for (int i = 0; i < 10; i++) drive_w(8'(250 + i), 5);
    tick(6);
    check("wrap_pass", pass_w, 1);
    check("wrap_fail", fail_w, 0);
    check("wrap_timeout", timeout_w, 0);
    check("wrap_steps", step_cnt_w - base, 9);
    check("wrap_expected", expected_w, 3);
    check("wrap_mismatch", mismatch_w, 0);
    enable_w = 1'b0;

    // One-cycle 0x0F glitch between 7 and 8 is filtered out.
    vec_in = '0;
    tick(3);
    enable = 1'b1;
    base = step_cnt;
    for (int v = 0; v <= 7; v++) drive(8'(v), 10);
    drive(8'h0F, 1);
    for (int v = 8; v <= 33; v++) drive(8'(v), 10);
    tick(6);
    check("glitch_pass", pass, 1);
    check("glitch_fail", fail, 0);
    check("glitch_steps", step_cnt - base, 33);

    // Disable, re-run to 12, then reset in the middle of TRACK.
    enable = 1'b0; vec_in = '0;
    tick(3);
    check("dis_pass", pass, 0);
    enable = 1'b1;
    for (int v = 0; v <= 12; v++) drive(8'(v), 10);
    tick(4);
    check("mid_busy", busy, 1);
    check("mid_expected", expected, 13);
    check("mid_state", state_dbg, 2);
    reset = 1'b1;
    tick(2);
    check_reset_vals();
    enable = 1'b0; vec_in = '0;
    reset = 1'b0;
    tick(2);
    check("post_rst_fail", fail, 0);
    enable = 1'b1;
    base = step_cnt;
    for (int v = 0; v <= 33; v++) drive(8'(v), 10);
    tick(6);
    check("rerun_pass", pass, 1);
    check("rerun_steps", step_cnt - base, 33);

    // Random segment streams.
    for (int t = 0; t < 20; t++) begin
      enable = 1'b0; vec_in = 8'd200;
      tick(3);
      segs.delete();
      repeat ($urandom_range(0, 2)) push_seg(8'($urandom_range(1, 255)), $urandom_range(4, 8));
      push_seg(8'd0, $urandom_range(4, 8));
      cur = 0; last_real = 8'd0; prev_glitch = 1'b0;
      for (int k = 0; k < 60 && cur < 33; k++) begin
        r = $urandom_range(0, 199);
        dur = $urandom_range(4, 8);
        if (r < 16 && !prev_glitch) begin
          push_seg(8'($urandom_range(0, 255)), 1);
          prev_glitch = 1'b1;
        end else begin
          prev_glitch = 1'b0;
          if (r < 36) begin
            push_seg(last_real, dur);
          end else if (r < 39) begin
            last_real = 8'($urandom_range(0, 255));
            push_seg(last_real, dur);
          end else begin
            cur++;
            last_real = 8'(cur);
            push_seg(last_real, dur);
          end
        end
      end
      push_seg(last_real, 8);
      run_model(m_pass, m_fail, m_exp, m_mis, m_steps);
      base = step_cnt;
      enable = 1'b1;
      foreach (segs[i]) drive(segs[i].v, segs[i].dur);
      check("rnd_pass", pass, m_pass);
      check("rnd_fail", fail, m_fail);
      check("rnd_timeout", timeout, 0);
      check("rnd_expected", expected, m_exp);
      check("rnd_steps", step_cnt - base, m_steps);
      check("rnd_busy", busy, (m_pass == 0 && m_fail == 0) ? 1 : 0);
      check("rnd_mismatch", mismatch_val, CAPTURE ? m_mis : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Run-time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
